// File: rtl/db_pkg.sv
// Shared opcode and FSM state encodings for the data-bank sequencer.
package db_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WR   = 2'b01,
        RD   = 2'b10,
        CLR  = 2'b11
    } state_e;

endpackage

// File: rtl/db_burst_ctr.sv
// Loadable wrapping address counter with a remaining-beat down-counter and last flag.
module db_burst_ctr #(
    parameter int NR    = 32,
    parameter int ADDRW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [ADDRW-1:0] base_i,
    input  logic [ADDRW-1:0] len_i,
    input  logic             step_i,
    output logic [ADDRW-1:0] addr_o,
    output logic [ADDRW-1:0] addr_nxt_o,
    output logic             last_o
);

    logic [ADDRW-1:0] addr_q, addr_d;
    logic [ADDRW:0]   rem_q, rem_d;

    assign addr_nxt_o = (addr_q == ADDRW'(NR - 1)) ? '0 : addr_q + 1'b1;
    assign addr_o     = addr_q;
    assign last_o     = (rem_q == (ADDRW + 1)'(1));

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = base_i;
            // A length of zero means a full sweep of the bank.
            rem_d  = (len_i == '0) ? (ADDRW + 1)'(NR) : {1'b0, len_i};
        end else if (step_i && (rem_q != '0)) begin
            addr_d = addr_nxt_o;
            rem_d  = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

endmodule

// File: rtl/db_seq.sv
// Command-driven sequencer for a dual-read-port register bank: burst write,
// paired burst read with output backpressure, and full-bank clear.
module db_seq
    import db_pkg::*;
#(
    parameter int W     = 24,
    parameter int NR    = 32,
    parameter int ADDRW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [ADDRW-1:0] cmd_addr_a,
    input  logic [ADDRW-1:0] cmd_addr_b,
    input  logic [ADDRW-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_a,
    output logic [W-1:0]     out_b,
    output logic             write,
    output logic [ADDRW-1:0] dira,
    output logic [ADDRW-1:0] dirb,
    output logic [W-1:0]     data,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    output logic             done
);

    state_e           state_q, state_d;
    logic             write_q, write_d;
    logic [ADDRW-1:0] dira_q, dira_d;
    logic [ADDRW-1:0] dirb_q, dirb_d;
    logic [W-1:0]     data_q, data_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_a_q, out_a_d;
    logic [W-1:0]     out_b_q, out_b_d;
    logic             done_q, done_d;
    logic             last_pair_q, last_pair_d;

    logic             ld_a, ld_b, step_a, step_b;
    logic [ADDRW-1:0] ld_base_a, ld_len_a;
    logic [ADDRW-1:0] a_addr, a_nxt, b_addr, b_nxt;
    logic             a_last, b_last;

    logic cmd_acc, in_acc, capture, pair_acc;

    assign cmd_ready = (state_q == IDLE) && !out_valid_q;
    assign in_ready  = (state_q == WR);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign in_acc    = in_valid && in_ready;
    assign pair_acc  = out_valid_q && out_ready;
    assign capture   = (state_q == RD) && (!out_valid_q || out_ready);

    db_burst_ctr #(.NR(NR), .ADDRW(ADDRW)) u_ctr_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ld_a),
        .base_i     (ld_base_a),
        .len_i      (ld_len_a),
        .step_i     (step_a),
        .addr_o     (a_addr),
        .addr_nxt_o (a_nxt),
        .last_o     (a_last)
    );

    db_burst_ctr #(.NR(NR), .ADDRW(ADDRW)) u_ctr_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ld_b),
        .base_i     (cmd_addr_b),
        .len_i      (cmd_len),
        .step_i     (step_b),
        .addr_o     (b_addr),
        .addr_nxt_o (b_nxt),
        .last_o     (b_last)
    );

    always_comb begin
        state_d     = state_q;
        write_d     = 1'b0;
        dira_d      = dira_q;
        dirb_d      = dirb_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        done_d      = 1'b0;
        last_pair_d = last_pair_q;
        ld_a        = 1'b0;
        ld_b        = 1'b0;
        ld_base_a   = cmd_addr_a;
        ld_len_a    = cmd_len;
        step_a      = 1'b0;
        step_b      = 1'b0;

        if (pair_acc) begin
            out_valid_d = 1'b0;
            last_pair_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    ld_a = 1'b1;
                    ld_b = 1'b1;
                    unique case (op_e'(cmd_op))
                        OP_WRITE: state_d = WR;
                        OP_READ: begin
                            state_d = RD;
                            dira_d  = cmd_addr_a;
                            dirb_d  = cmd_addr_b;
                        end
                        OP_CLEAR: begin
                            state_d   = CLR;
                            ld_base_a = '0;
                            ld_len_a  = '0;
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            WR: begin
                if (in_acc) begin
                    write_d = 1'b1;
                    dira_d  = a_addr;
                    data_d  = in_data;
                    step_a  = 1'b1;
                    // Leave WR on the final beat so no extra beat is taken during its write cycle.
                    if (a_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            RD: begin
                dira_d = a_addr;
                dirb_d = b_addr;
                if (capture) begin
                    out_a_d     = A;
                    out_b_d     = B;
                    out_valid_d = 1'b1;
                    step_a      = 1'b1;
                    step_b      = 1'b1;
                    dira_d      = a_nxt;
                    dirb_d      = b_nxt;
                    if (a_last && b_last) begin
                        last_pair_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            CLR: begin
                write_d = 1'b1;
                dira_d  = a_addr;
                data_d  = '0;
                step_a  = 1'b1;
                if (a_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            dira_q      <= '0;
            dirb_q      <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            done_q      <= 1'b0;
            last_pair_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            dira_q      <= dira_d;
            dirb_q      <= dirb_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            done_q      <= done_d;
            last_pair_q <= last_pair_d;
        end
    end

    assign write     = write_q;
    assign dira      = dira_q;
    assign dirb      = dirb_q;
    assign data      = data_q;
    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    // A read completes when its final pair is consumed, which is not a registered event.
    assign done      = done_q | (last_pair_q & pair_acc);

endmodule

// File: tb/tb_db_seq.sv
// Directed scoreboard bench for db_seq with a behavioural dual-port register bank.
module tb_db_seq;
    import db_pkg::*;

    localparam int W     = 24;
    localparam int NR    = 32;
    localparam int ADDRW = 5;

    logic             clk, rst_n;
    logic             cmd_valid, cmd_ready;
    logic [1:0]       cmd_op;
    logic [ADDRW-1:0] cmd_addr_a, cmd_addr_b, cmd_len;
    logic             in_valid, in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid, out_ready;
    logic [W-1:0]     out_a, out_b;
    logic             write;
    logic [ADDRW-1:0] dira, dirb;
    logic [W-1:0]     data, A, B;
    logic             done;

    logic [W-1:0] mem    [NR];
    logic [W-1:0] shadow [NR];

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [W-1:0]     data;
        logic             last;
    } wexp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         last;
    } rexp_t;

    wexp_t wq[$];
    rexp_t rq[$];
    int    acc_cyc[$];

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int n_cmds   = 0;

    logic         hold_prev = 1'b0;
    logic [W-1:0] prev_a, prev_b;

    db_seq #(.W(W), .NR(NR), .ADDRW(ADDRW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr_a (cmd_addr_a),
        .cmd_addr_b (cmd_addr_b),
        .cmd_len    (cmd_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .write      (write),
        .dira       (dira),
        .dirb       (dirb),
        .data       (data),
        .A          (A),
        .B          (B),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (write) mem[dira] <= data;
    assign A = mem[dira];
    assign B = (write && (dirb == dira)) ? data : mem[dirb];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] patt(input int i);
        return {8'hA5, 8'(i), 8'h5A};
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            wexp_t we;
            rexp_t re;
            cyc++;
            if (done) done_cnt++;
            if (write) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 64'(write), 64'(0));
                end else begin
                    we = wq.pop_front();
                    chk("wr_addr", 64'(dira), 64'(we.addr));
                    chk("wr_data", 64'(data), 64'(we.data));
                    chk("wr_done", 64'(done), 64'(we.last));
                end
            end
            if (hold_prev) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_a", 64'(out_a), 64'(prev_a));
                chk("hold_b", 64'(out_b), 64'(prev_b));
            end
            if (out_valid && out_ready) begin
                if (rq.size() == 0) begin
                    chk("unexpected_pair", 64'(out_valid), 64'(0));
                end else begin
                    re = rq.pop_front();
                    chk("rd_a", 64'(out_a), 64'(re.a));
                    chk("rd_b", 64'(out_b), 64'(re.b));
                    chk("rd_done", 64'(done), 64'(re.last));
                end
                acc_cyc.push_back(cyc);
            end
            hold_prev = out_valid && !out_ready;
            prev_a    = out_a;
            prev_b    = out_b;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_write"}, 64'(write), 64'(0));
        chk({tag, "_dira"}, 64'(dira), 64'(0));
        chk({tag, "_dirb"}, 64'(dirb), 64'(0));
        chk({tag, "_data"}, 64'(data), 64'(0));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_out_a"}, 64'(out_a), 64'(0));
        chk({tag, "_out_b"}, 64'(out_b), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    endtask

    task automatic send_cmd(input op_e op, input int a, input int b, input int len);
        int n;
        n          = 0;
        cmd_op     = op;
        cmd_addr_a = ADDRW'(a);
        cmd_addr_b = ADDRW'(b);
        cmd_len    = ADDRW'(len);
        cmd_valid  = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_cmds++;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt < n_cmds && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 64'(done_cnt), 64'(n_cmds));
    endtask

    task automatic do_write(input int base, input int len, input logic [W-1:0] d0,
                            input bit use_patt, input bit gaps);
        int    n, ad, k;
        wexp_t e;
        logic [W-1:0] dv;
        n = (len == 0) ? NR : len;
        send_cmd(OP_WRITE, base, 0, len);
        if (gaps) begin
            cmd_valid = 1'b1;
            cmd_op    = OP_CLEAR;
        end
        for (int i = 0; i < n; i++) begin
            ad     = (base + i) % NR;
            dv     = use_patt ? patt(ad) : d0 + W'(i);
            e.addr = ADDRW'(ad);
            e.data = dv;
            e.last = (i == n - 1);
            wq.push_back(e);
            shadow[ADDRW'(ad)] = dv;
            if (gaps && i == 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = dv;
            k = 0;
            while (!in_ready && k < 50) begin
                @(posedge clk); #1;
                k++;
            end
            chk("in_ready_wait", 64'(in_ready), 64'(1));
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        cmd_valid = 1'b0;
        wait_done("wr_done_cnt");
    endtask

    task automatic do_read(input int a, input int b, input int len, input bit toggle);
        int    n, k;
        rexp_t e;
        n = (len == 0) ? NR : len;
        for (int i = 0; i < n; i++) begin
            e.a    = shadow[ADDRW'((a + i) % NR)];
            e.b    = shadow[ADDRW'((b + i) % NR)];
            e.last = (i == n - 1);
            rq.push_back(e);
        end
        acc_cyc.delete();
        out_ready = 1'b1;
        send_cmd(OP_READ, a, b, len);
        k = 0;
        while (done_cnt < n_cmds && k < 400) begin
            if (toggle) out_ready = ((k % 4) == 0) || ((k % 4) == 3);
            @(posedge clk); #1;
            k++;
        end
        out_ready = 1'b1;
        chk("rd_done_cnt", 64'(done_cnt), 64'(n_cmds));
        chk("rd_pairs", 64'(acc_cyc.size()), 64'(n));
        if (!toggle && acc_cyc.size() > 0)
            chk("rd_span", 64'(acc_cyc[$] - acc_cyc[0]), 64'(n - 1));
    endtask

    initial begin
        wexp_t e;
        rst_n      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = OP_NOP;
        cmd_addr_a = '0;
        cmd_addr_b = '0;
        cmd_len    = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_vals("por");
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-bank fill with the address pattern, then the short two-beat write.
        do_write(0, 0, '0, 1'b1, 1'b0);
        do_write(3, 2, '0, 1'b1, 1'b0);

        // Full-rate paired read, then a read under backpressure.
        do_read(0, 31, 0, 1'b0);
        do_read(10, 20, 3, 1'b1);

        // Wrapping write with a bubble and a competing command held on the port.
        do_write(30, 4, 24'h123400, 1'b0, 1'b1);
        do_read(29, 1, 5, 1'b0);

        send_cmd(OP_NOP, 0, 0, 0);
        wait_done("nop_done_cnt");

        for (int i = 0; i < NR; i++) begin
            e.addr = ADDRW'(i);
            e.data = '0;
            e.last = (i == NR - 1);
            wq.push_back(e);
            shadow[ADDRW'(i)] = '0;
        end
        send_cmd(OP_CLEAR, 9, 9, 3);
        wait_done("clr_done_cnt");
        do_read(5, 17, 4, 1'b0);

        // Reset in the middle of a five-beat write.
        send_cmd(OP_WRITE, 7, 0, 5);
        e.addr = ADDRW'(7);
        e.data = 24'hBEEF01;
        e.last = 1'b0;
        wq.push_back(e);
        in_valid = 1'b1;
        in_data  = 24'hBEEF01;
        @(posedge clk); #1;
        in_data  = 24'hBEEF02;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 check_reset_vals("mid_rst");
        n_cmds = n_cmds - 1;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("wq_empty", 64'(wq.size()), 64'(0));
        chk("rq_empty", 64'(rq.size()), 64'(0));
        chk("done_total", 64'(done_cnt), 64'(n_cmds));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
